// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the data-memory access controller.
// Holds the FSM state encoding, the RV32 load/store funct3 codes and a
// helper that flags funct3 values with no legal meaning.
package mem_access_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Stores only define SB/SH/SW; loads leave 011, 110 and 111 unused.
  function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
    if (is_store) return (f3 > F3_SW);
    return !(f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
  endfunction

endpackage

// File: rtl/load_store_align.sv
// Combinational lane handling for the memory access controller.
// Store side (live request): byte enables, lane-replicated write data and
//   fault detection (misalignment or illegal funct3).
// Load side (registered access info): selects the addressed lane of the
//   read word and sign- or zero-extends it.
// Ports:
//   is_store, funct3, addr_lo, wdata -> be, wdata_rep, fault
//   ld_funct3, ld_addr_lo, rdata     -> load_data
module load_store_align
  import mem_access_ctrl_pkg::*;
(
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic        fault,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] load_data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // funct3[1:0] is the access size for loads and stores alike, so the same
  // enables serve both directions.
  always_comb begin
    be        = '0;
    wdata_rep = '0;
    case (funct3[1:0])
      F3_SB[1:0]: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      F3_SH[1:0]: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
      end
      default: begin
        be        = '1;
        wdata_rep = wdata;
      end
    endcase
  end

  always_comb begin
    fault = f3_illegal(is_store, funct3);
    if ((funct3[1:0] == F3_SH[1:0]) && addr_lo[0])        fault = 1'b1;
    if ((funct3[1:0] == F3_SW[1:0]) && (addr_lo != 2'b00)) fault = 1'b1;
  end

  always_comb begin
    lane_b = '0;
    case (ld_addr_lo)
      2'd0:    lane_b = rdata[7:0];
      2'd1:    lane_b = rdata[15:8];
      2'd2:    lane_b = rdata[23:16];
      default: lane_b = rdata[31:24];
    endcase
    lane_h = ld_addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    load_data = '0;
    case (ld_funct3)
      F3_LB:   load_data = {{24{lane_b[7]}}, lane_b};
      F3_LH:   load_data = {{16{lane_h[15]}}, lane_h};
      F3_LW:   load_data = rdata;
      F3_LBU:  load_data = {24'd0, lane_b};
      F3_LHU:  load_data = {16'd0, lane_h};
      default: load_data = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller.
// Accepts a load/store from the pipeline, stalls it while a single request
// is held on the memory port until ready (or timeout), then releases the
// pipeline for one DONE cycle in which load results are presented.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   mem_read_i, mem_write_i       MEM-stage load/store request
//   addr_i, wdata_i, funct3_i     byte address, store data, width/sign code
//   dmem_req_o/we_o/addr_o/be_o/wdata_o, dmem_ready_i, dmem_rdata_i
//                                 memory port
//   stall_o                       hold the pipeline
//   load_data_o, load_valid_o     formatted load result
//   fault_o                       misaligned or illegal access (IDLE only)
//   timeout_o                     one-cycle pulse after a timed-out access
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [2:0]  funct3_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ready_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        stall_o,
  output logic [31:0] load_data_o,
  output logic        load_valid_o,
  output logic        fault_o,
  output logic        timeout_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [29:0]       waddr_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic              timeout_q;
  logic [31:0]       load_q;

  logic              req;
  logic              fault;
  logic              expire;
  logic [3:0]        be_c;
  logic [31:0]       wdata_c;
  logic [31:0]       ld_fmt;

  assign req    = mem_read_i | mem_write_i;
  assign expire = (cnt == CNT_LAST);

  load_store_align u_align (
    .is_store   (mem_write_i),
    .funct3     (funct3_i),
    .addr_lo    (addr_i[1:0]),
    .wdata      (wdata_i),
    .be         (be_c),
    .wdata_rep  (wdata_c),
    .fault      (fault),
    .ld_funct3  (f3_q),
    .ld_addr_lo (off_q),
    .rdata      (dmem_rdata_i),
    .load_data  (ld_fmt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      waddr_q   <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      f3_q      <= '0;
      off_q     <= '0;
      timeout_q <= 1'b0;
      load_q    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (req && !fault) begin
            waddr_q   <= addr_i[31:2];
            be_q      <= be_c;
            wdata_q   <= wdata_c;
            we_q      <= mem_write_i;
            f3_q      <= funct3_i;
            off_q     <= addr_i[1:0];
            cnt       <= '0;
            timeout_q <= 1'b0;
          end
        end
        ACCESS: begin
          // Ready wins over an expiry in the same cycle.
          if (dmem_ready_i) begin
            if (!we_q) load_q <= ld_fmt;
          end else if (expire) begin
            load_q    <= '0;
            timeout_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt    = state;
    dmem_req_o   = 1'b0;
    dmem_we_o    = 1'b0;
    dmem_addr_o  = '0;
    dmem_be_o    = '0;
    dmem_wdata_o = '0;
    stall_o      = 1'b0;
    load_valid_o = 1'b0;
    fault_o      = 1'b0;
    timeout_o    = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (fault) begin
            fault_o = 1'b1;
          end else begin
            stall_o   = 1'b1;
            state_nxt = ACCESS;
          end
        end
      end
      ACCESS: begin
        dmem_req_o   = 1'b1;
        dmem_we_o    = we_q;
        dmem_addr_o  = {waddr_q, 2'b00};
        dmem_be_o    = be_q;
        dmem_wdata_o = wdata_q;
        stall_o      = 1'b1;
        if (dmem_ready_i || expire) state_nxt = DONE;
      end
      DONE: begin
        load_valid_o = !we_q;
        timeout_o    = timeout_q;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Reset must pull the request off the port in the cycle it is seen.
    if (rst) begin
      state_nxt    = IDLE;
      dmem_req_o   = 1'b0;
      dmem_we_o    = 1'b0;
      dmem_addr_o  = '0;
      dmem_be_o    = '0;
      dmem_wdata_o = '0;
      stall_o      = 1'b0;
      load_valid_o = 1'b0;
      fault_o      = 1'b0;
      timeout_o    = 1'b0;
    end
  end

  assign load_data_o = load_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_i, mem_write_i;
  logic [31:0] addr_i, wdata_i;
  logic [2:0]  funct3_i;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_ready_i;
  logic [31:0] dmem_rdata_i;
  logic        stall_o;
  logic [31:0] load_data_o;
  logic        load_valid_o, fault_o, timeout_o;

  int checks   = 0;
  int failures = 0;
  logic [31:0] last_ld = '0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int unsigned delay;
    logic        fault;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] ld;
  } vec_t;

  vec_t vecs[15];
  vec_t sb[$];

  mem_access_ctrl #(.TIMEOUT_CYCLES(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_read_i   (mem_read_i),
    .mem_write_i  (mem_write_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .funct3_i     (funct3_i),
    .dmem_req_o   (dmem_req_o),
    .dmem_we_o    (dmem_we_o),
    .dmem_addr_o  (dmem_addr_o),
    .dmem_be_o    (dmem_be_o),
    .dmem_wdata_o (dmem_wdata_o),
    .dmem_ready_i (dmem_ready_i),
    .dmem_rdata_i (dmem_rdata_i),
    .stall_o      (stall_o),
    .load_data_o  (load_data_o),
    .load_valid_o (load_valid_o),
    .fault_o      (fault_o),
    .timeout_o    (timeout_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int unsigned delay,
                              input logic fault, input logic [3:0] be,
                              input logic [31:0] wd, input logic [31:0] ld);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.delay = delay; v.fault = fault; v.be = be;
    v.wd = wd; v.ld = ld;
    return v;
  endfunction

  task automatic idle_inputs();
    mem_read_i   = 1'b0;
    mem_write_i  = 1'b0;
    addr_i       = '0;
    wdata_i      = '0;
    funct3_i     = '0;
    dmem_ready_i = 1'b0;
    dmem_rdata_i = '0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_req"},   dmem_req_o,   0);
    chk({tag, "_we"},    dmem_we_o,    0);
    chk({tag, "_addr"},  dmem_addr_o,  0);
    chk({tag, "_be"},    dmem_be_o,    0);
    chk({tag, "_wdata"}, dmem_wdata_o, 0);
    chk({tag, "_stall"}, stall_o,      0);
    chk({tag, "_ld"},    load_data_o,  0);
    chk({tag, "_valid"}, load_valid_o, 0);
    chk({tag, "_fault"}, fault_o,      0);
    chk({tag, "_tmo"},   timeout_o,    0);
  endtask

  task automatic run_vec(input vec_t v);
    vec_t e;
    @(negedge clk);
    mem_read_i   = v.rd;
    mem_write_i  = v.wr;
    addr_i       = v.addr;
    wdata_i      = v.wdata;
    funct3_i     = v.f3;
    dmem_ready_i = 1'b0;
    sb.push_back(v);
    #1;
    if (v.fault) begin
      e = sb.pop_front();
      chk("fault_o",     fault_o,    e.fault);
      chk("fault_stall", stall_o,    0);
      chk("fault_req",   dmem_req_o, 0);
      @(negedge clk);
      idle_inputs();
      #1;
      chk("fault_stay_req",   dmem_req_o, 0);
      chk("fault_stay_stall", stall_o,    0);
      return;
    end
    chk("t0_stall", stall_o,    1);
    chk("t0_fault", fault_o,    0);
    chk("t0_req",   dmem_req_o, 0);
    // Request inputs change during ACCESS; the port must stay on the captured values.
    @(negedge clk);
    mem_read_i  = 1'b0;
    mem_write_i = 1'b0;
    addr_i      = $urandom;
    wdata_i     = $urandom;
    funct3_i    = 3'b111;
    for (int unsigned i = 0; i < v.delay; i++) begin
      #1;
      chk("wait_req",   dmem_req_o, 1);
      chk("wait_stall", stall_o,    1);
      @(negedge clk);
    end
    dmem_ready_i = 1'b1;
    dmem_rdata_i = v.rdata;
    #1;
    chk("acc_req",   dmem_req_o,  1);
    chk("acc_stall", stall_o,     1);
    chk("acc_we",    dmem_we_o,   v.wr);
    chk("acc_addr",  dmem_addr_o, v.addr & 32'hFFFF_FFFC);
    chk("acc_be",    dmem_be_o,   v.be);
    if (v.wr) chk("acc_wdata", dmem_wdata_o, v.wd);
    @(negedge clk);
    dmem_ready_i = 1'b0;
    dmem_rdata_i = $urandom;
    #1;
    e = sb.pop_front();
    chk("done_stall", stall_o,      0);
    chk("done_req",   dmem_req_o,   0);
    chk("done_valid", load_valid_o, !e.wr);
    chk("done_tmo",   timeout_o,    0);
    if (!e.wr) last_ld = e.ld;
    chk("done_ld",    load_data_o,  last_ld);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("hold_ld",    load_data_o,  last_ld);
    chk("hold_valid", load_valid_o, 0);
  endtask

  initial begin
    vecs[0]  = mk(0, 1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,         0, 0, 4'b1111, 32'hDEAD_BEEF, 32'h0);
    vecs[1]  = mk(1, 0, 3'b000, 32'h0000_0103, 32'h0,         32'h8000_0000, 0, 0, 4'b1000, 32'h0,         32'hFFFF_FF80);
    vecs[2]  = mk(1, 0, 3'b100, 32'h0000_0103, 32'h0,         32'h8000_0000, 1, 0, 4'b1000, 32'h0,         32'h0000_0080);
    vecs[3]  = mk(0, 1, 3'b001, 32'h0000_0102, 32'h0000_1234, 32'h0,         0, 0, 4'b1100, 32'h1234_1234, 32'h0);
    vecs[4]  = mk(1, 0, 3'b010, 32'h0000_0101, 32'h0,         32'h0,         0, 1, 4'b0000, 32'h0,         32'h0);
    vecs[5]  = mk(1, 0, 3'b001, 32'h0000_0202, 32'h0,         32'h8001_7FFF, 2, 0, 4'b1100, 32'h0,         32'hFFFF_8001);
    vecs[6]  = mk(1, 0, 3'b101, 32'h0000_0200, 32'h0,         32'h1234_F00D, 0, 0, 4'b0011, 32'h0,         32'h0000_F00D);
    vecs[7]  = mk(0, 1, 3'b000, 32'h0000_0301, 32'h1234_56A5, 32'h0,         1, 0, 4'b0010, 32'hA5A5_A5A5, 32'h0);
    vecs[8]  = mk(1, 0, 3'b010, 32'h0000_0400, 32'h0,         32'hCAFE_F00D, 3, 0, 4'b1111, 32'h0,         32'hCAFE_F00D);
    vecs[9]  = mk(0, 1, 3'b001, 32'h0000_0103, 32'h0,         32'h0,         0, 1, 4'b0000, 32'h0,         32'h0);
    vecs[10] = mk(1, 0, 3'b011, 32'h0000_0000, 32'h0,         32'h0,         0, 1, 4'b0000, 32'h0,         32'h0);
    vecs[11] = mk(0, 1, 3'b011, 32'h0000_0000, 32'h0,         32'h0,         0, 1, 4'b0000, 32'h0,         32'h0);
    vecs[12] = mk(1, 1, 3'b010, 32'h0000_0500, 32'h1122_3344, 32'h5555_5555, 0, 0, 4'b1111, 32'h1122_3344, 32'h0);
    vecs[13] = mk(1, 0, 3'b110, 32'h0000_0008, 32'h0,         32'h0,         0, 1, 4'b0000, 32'h0,         32'h0);
    vecs[14] = mk(1, 0, 3'b000, 32'h0000_0001, 32'h0,         32'h0000_7F00, 0, 0, 4'b0010, 32'h0,         32'h0000_007F);

    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) run_vec(vecs[i]);

    // Reset in the third ACCESS cycle of a load.
    @(negedge clk);
    mem_read_i = 1'b1;
    addr_i     = 32'h0000_0700;
    funct3_i   = 3'b010;
    @(negedge clk);
    idle_inputs();
    #1;
    chk("rst_acc1_req", dmem_req_o, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_same_cycle_req",   dmem_req_o, 0);
    chk("rst_same_cycle_stall", stall_o,    0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all_zero("rst_mid");
    last_ld = '0;
    @(negedge clk);
    #1;
    chk("rst_stays_idle_req", dmem_req_o, 0);

    // Restore a non-zero load result so the timeout zeroing is visible.
    run_vec(vecs[8]);

    // LW that never completes: 64 ACCESS cycles, then DONE with a timeout pulse.
    @(negedge clk);
    mem_read_i = 1'b1;
    addr_i     = 32'h0000_0600;
    funct3_i   = 3'b010;
    #1;
    chk("tmo_t0_stall", stall_o, 1);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      idle_inputs();
      #1;
      if (i == 0 || i == 63) begin
        chk("tmo_acc_req",   dmem_req_o, 1);
        chk("tmo_acc_stall", stall_o,    1);
        chk("tmo_acc_pulse", timeout_o,  0);
      end
    end
    @(negedge clk);
    #1;
    chk("tmo_pulse", timeout_o,   1);
    chk("tmo_stall", stall_o,     0);
    chk("tmo_req",   dmem_req_o,  0);
    chk("tmo_ld",    load_data_o, 0);
    @(negedge clk);
    #1;
    chk("tmo_pulse_end", timeout_o,   0);
    chk("tmo_ld_hold",   load_data_o, 0);
    chk("tmo_idle_req",  dmem_req_o,  0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64: maximum ACCESS cycles to wait for dmem_ready_i.
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 mem_read_i  in  1  MEM-stage load request.
REQ-006 mem_write_i  in  1  MEM-stage store request.
REQ-007 addr_i  in  32  byte address (EX result).
REQ-008 wdata_i  in  32  store data (rs2).
REQ-009 funct3_i  in  3  load/store width/sign code.
REQ-010 dmem_req_o  out  1  memory request.
REQ-011 dmem_we_o  out  1  write enable.
REQ-012 dmem_addr_o  out  32  word-aligned address, addr[1:0]=0.
REQ-013 dmem_be_o  out  4  byte enables.
REQ-014 dmem_wdata_o  out  32  lane-replicated store data.
REQ-015 dmem_ready_i  in  1  memory completion.
REQ-016 dmem_rdata_i  in  32  memory read word.
REQ-017 stall_o  out  1  hold the pipeline.
REQ-018 load_data_o  out  32  formatted load result.
REQ-019 load_valid_o  out  1  load_data_o valid.
REQ-020 fault_o  out  1  misaligned address or illegal funct3.
REQ-021 timeout_o  out  1  one-cycle pulse on memory timeout.

Function
REQ-022 SHALL implement FSM states IDLE, ACCESS and DONE.
REQ-023 IDLE, legal request: SHALL assert stall_o combinationally, register addr/be/wdata/we, and enter ACCESS.
REQ-024 When mem_read_i and mem_write_i are both high, SHALL perform the write and ignore the read.
REQ-025 ACCESS: SHALL hold dmem_req_o=1 with addr, be, we and wdata stable, keep stall_o=1, and count cycles.
REQ-026 ACCESS with dmem_ready_i=1: SHALL capture the formatted rdata and enter DONE at the next edge.
REQ-027 DONE: SHALL drive stall_o=0 and dmem_req_o=0; load_valid_o=1 for loads only; inputs ignored; SHALL return to IDLE next cycle.
REQ-028 Minimum latency: request seen at T0, ready at T1, load_valid_o at T2; stall_o high during T0-T1.
REQ-029 Cycle counter SHALL reset on entering ACCESS. On reaching TIMEOUT_CYCLES without ready, SHALL drop the request, pulse timeout_o, and enter DONE with load_data_o=0.
REQ-030 Fault conditions: LH/LHU/SH with addr[0]=1, LW/SW with addr[1:0]!=0, load funct3 in {011,110,111}, or store funct3 >= 011.
REQ-031 On a fault: fault_o=1 combinationally in IDLE, no dmem_req_o, stall_o=0, FSM stays in IDLE.
REQ-032 Store byte enables: SB be=1<<addr[1:0], byte replicated x4; SH be=0011 or 1100, halfword replicated x2; SW be=1111.
REQ-033 Load format: LB/LH sign-extend the selected lane; LBU/LHU zero-extend; LW passes the word.
REQ-034 load_data_o SHALL hold its value from DONE until the next capture.

Reset
REQ-035 rst SHALL force IDLE and clear the counter at the next edge, including mid-ACCESS; dmem_req_o drops the same cycle.
REQ-036 Reset values: all outputs 0; load_data_o=0.

Structure
REQ-037 FSM state encoding and load/store funct3 constants SHALL reside in the shared defines package.
REQ-038 Lane select, byte enables and sign extension SHALL be a combinational sub-module load_store_align.

Verification
REQ-039 SW addr=0x100, wdata=0xDEADBEEF, ready at T1 -> be=1111, wdata=0xDEADBEEF, stall_o high for 2 cycles.
REQ-040 LB addr=0x103, rdata=0x80000000 -> load_data_o=0xFFFFFF80; LBU same access -> 0x00000080.
REQ-041 SH addr=0x102, wdata=0x1234 -> be=1100, dmem_wdata_o=0x12341234, dmem_addr_o=0x100.
REQ-042 LW addr=0x101 -> fault_o=1, no dmem_req_o, stall_o=0.
REQ-043 LW with dmem_ready_i held low for 64 cycles -> timeout_o pulse, load_data_o=0, stall_o releases.
REQ-044 rst asserted in the third ACCESS cycle -> IDLE next cycle, dmem_req_o=0, all outputs 0.
